// File: rtl/logic_unit_pipe.sv
// logic_unit_pipe: pipelined bitwise logic unit with a 2-entry result FIFO.
//
// Operands are accepted on valid_in && ready_op. Each accepted operand produces one
// result one cycle later in a 2-entry FIFO, drained on valid_op && ready_in in
// acceptance order. Opcode 7 is illegal: it yields an all-zero result and sets the
// sticky err_op flag.
//
// Optional feature (macro LOGIC_UNIT_SELFTEST_EN): a built-in self-test FSM that
// sweeps all legal opcodes over every (a,b) bit combination and reports pass/fail.
// Without the macro, start_in is ignored and busy_op/done_op/pass_op are tied to 0.
//
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   valid_in, ready_op   operand handshake (ready_op is registered)
//   a_in, b_in           WIDTH-bit operands
//   op_sel_in            3-bit operation select
//   valid_op, ready_in   result handshake
//   result_op            WIDTH-bit result (0 when FIFO empty)
//   err_op               sticky illegal-opcode flag
//   start_in             self-test start
//   busy_op, done_op     self-test status
//   pass_op              self-test verdict, held until next start or reset
module logic_unit_pipe #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             valid_in,
   output logic             ready_op,
   input  logic [WIDTH-1:0] a_in,
   input  logic [WIDTH-1:0] b_in,
   input  logic [2:0]       op_sel_in,
   output logic             valid_op,
   input  logic             ready_in,
   output logic [WIDTH-1:0] result_op,
   output logic             err_op,
   input  logic             start_in,
   output logic             busy_op,
   output logic             done_op,
   output logic             pass_op
);

   function automatic logic [WIDTH-1:0] lu_eval(input logic [2:0]       op,
                                                input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b);
      logic [WIDTH-1:0] r;
      case (op)
         3'd0:    r = ~a;
         3'd1:    r = a & b;
         3'd2:    r = ~(a & b);
         3'd3:    r = a | b;
         3'd4:    r = ~(a | b);
         3'd5:    r = a ^ b;
         3'd6:    r = ~(a ^ b);
         default: r = '0;
      endcase
      return r;
   endfunction

   // ---------------------------------------------------------------------------
   // Result FIFO
   // ---------------------------------------------------------------------------
   logic [WIDTH-1:0] mem_q [2];
   logic [WIDTH-1:0] mem_d [2];
   logic             rd_ptr_q, rd_ptr_d;
   logic             wr_ptr_q, wr_ptr_d;
   logic [1:0]       count_q, count_d;
   logic             ready_q, ready_d;
   logic             err_q, err_d;
   logic             push, pop;
   logic             st_active_d;

   assign push = valid_in && ready_q;
   assign pop  = (count_q != 2'd0) && ready_in;

   always_comb begin
      mem_d    = mem_q;
      if (push) begin
         mem_d[wr_ptr_q] = lu_eval(op_sel_in, a_in, b_in);
      end
      wr_ptr_d = wr_ptr_q ^ push;
      rd_ptr_d = rd_ptr_q ^ pop;
      count_d  = count_q + {1'b0, push} - {1'b0, pop};
      err_d    = err_q | (push && (op_sel_in == 3'd7));
      // Registered ready looks at next occupancy, so it never depends on ready_in
      // combinationally yet still reopens the cycle after a pop from full.
      ready_d  = (count_d != 2'd2) && !st_active_d;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mem_q[0] <= '0;
         mem_q[1] <= '0;
         rd_ptr_q <= 1'b0;
         wr_ptr_q <= 1'b0;
         count_q  <= 2'd0;
         ready_q  <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         mem_q    <= mem_d;
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
         ready_q  <= ready_d;
         err_q    <= err_d;
      end
   end

   assign ready_op  = ready_q;
   assign valid_op  = (count_q != 2'd0);
   assign result_op = valid_op ? mem_q[rd_ptr_q] : '0;
   assign err_op    = err_q;

`ifdef LOGIC_UNIT_SELFTEST_EN
   // ---------------------------------------------------------------------------
   // Self-test FSM
   // ---------------------------------------------------------------------------
   typedef enum logic [2:0] {StIdle, StWaitEmpty, StRun, StCheck, StDone} st_state_e;

   // Expected bit for vector index {op, a, b}; nibble per opcode, op 6 at the top.
   localparam logic [27:0] SweepExp = 28'h961E783;

   st_state_e        st_state_q, st_state_d;
   logic [4:0]       st_idx_q, st_idx_d;
   logic [WIDTH-1:0] st_res_q, st_res_d;
   logic [WIDTH-1:0] st_exp_q, st_exp_d;
   logic             st_cmp_q, st_cmp_d;
   logic             st_fail_q, st_fail_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             pass_q, pass_d;
   logic             st_miss;

   // The previous vector's result is compared while the next one is computed.
   assign st_miss = st_cmp_q && (st_res_q != st_exp_q);

   always_comb begin
      st_state_d = st_state_q;
      st_idx_d   = st_idx_q;
      st_res_d   = st_res_q;
      st_exp_d   = st_exp_q;
      st_cmp_d   = st_cmp_q;
      st_fail_d  = st_fail_q;
      pass_d     = pass_q;
      case (st_state_q)
         StIdle: begin
            if (start_in) begin
               st_state_d = StWaitEmpty;
               st_idx_d   = 5'd0;
               st_cmp_d   = 1'b0;
               st_fail_d  = 1'b0;
               pass_d     = 1'b0;
            end
         end
         StWaitEmpty: begin
            if (count_q == 2'd0) begin
               st_state_d = StRun;
            end
         end
         StRun: begin
            st_res_d  = lu_eval(st_idx_q[4:2], {WIDTH{st_idx_q[1]}}, {WIDTH{st_idx_q[0]}});
            st_exp_d  = {WIDTH{SweepExp[st_idx_q]}};
            st_cmp_d  = 1'b1;
            st_fail_d = st_fail_q | st_miss;
            st_idx_d  = st_idx_q + 5'd1;
            if (st_idx_q == 5'd27) begin
               st_state_d = StCheck;
            end
         end
         StCheck: begin
            st_fail_d  = st_fail_q | st_miss;
            pass_d     = !(st_fail_q || st_miss);
            st_cmp_d   = 1'b0;
            st_state_d = StDone;
         end
         StDone: begin
            st_state_d = StIdle;
         end
         default: begin
            st_state_d = StIdle;
         end
      endcase
      busy_d = (st_state_d == StWaitEmpty) || (st_state_d == StRun) ||
               (st_state_d == StCheck);
      done_d = (st_state_d == StDone);
   end

   assign st_active_d = busy_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         st_state_q <= StIdle;
         st_idx_q   <= 5'd0;
         st_res_q   <= '0;
         st_exp_q   <= '0;
         st_cmp_q   <= 1'b0;
         st_fail_q  <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         pass_q     <= 1'b0;
      end else begin
         st_state_q <= st_state_d;
         st_idx_q   <= st_idx_d;
         st_res_q   <= st_res_d;
         st_exp_q   <= st_exp_d;
         st_cmp_q   <= st_cmp_d;
         st_fail_q  <= st_fail_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         pass_q     <= pass_d;
      end
   end

   assign busy_op = busy_q;
   assign done_op = done_q;
   assign pass_op = pass_q;
`else
   logic unused_start;
   assign unused_start = start_in;
   assign st_active_d  = 1'b0;
   assign busy_op      = 1'b0;
   assign done_op      = 1'b0;
   assign pass_op      = 1'b0;
`endif

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Scoreboard bench for logic_unit_pipe (WIDTH=8). Accepted operands push a model
// result; a monitor process pops and compares on every result transfer and also
// checks valid/ready/err against the model occupancy.
module tb_logic_unit_pipe;

   localparam int unsigned W = 8;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         valid_in = 1'b0;
   logic         ready_op;
   logic [W-1:0] a_in = '0;
   logic [W-1:0] b_in = '0;
   logic [2:0]   op_sel_in = 3'd0;
   logic         valid_op;
   logic         ready_in = 1'b0;
   logic [W-1:0] result_op;
   logic         err_op;
   logic         start_in = 1'b0;
   logic         busy_op;
   logic         done_op;
   logic         pass_op;

   int           n_vec = 0;
   int           n_err = 0;
   logic [W-1:0] sb[$];
   logic         err_model = 1'b0;
   logic         mon_en = 1'b0;

   logic_unit_pipe #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .valid_in  (valid_in),
      .ready_op  (ready_op),
      .a_in      (a_in),
      .b_in      (b_in),
      .op_sel_in (op_sel_in),
      .valid_op  (valid_op),
      .ready_in  (ready_in),
      .result_op (result_op),
      .err_op    (err_op),
      .start_in  (start_in),
      .busy_op   (busy_op),
      .done_op   (done_op),
      .pass_op   (pass_op)
   );

   always #5 clk = ~clk;

   // Reference: each result bit is the named boolean function of the operand bits.
   function automatic logic [W-1:0] model(input logic [2:0] op, input logic [W-1:0] a,
                                          input logic [W-1:0] b);
      logic [W-1:0] r;
      for (int i = 0; i < W; i++) begin
         case (op)
            3'd0:    r[i] = !a[i];
            3'd1:    r[i] = a[i] && b[i];
            3'd2:    r[i] = !(a[i] && b[i]);
            3'd3:    r[i] = a[i] || b[i];
            3'd4:    r[i] = !(a[i] || b[i]);
            3'd5:    r[i] = a[i] != b[i];
            3'd6:    r[i] = a[i] == b[i];
            default: r[i] = 1'b0;
         endcase
      end
      return r;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Stimulus side of the scoreboard: record every accepted operand.
   always @(negedge clk) begin
      #2;
      if (!rst && valid_in && ready_op) begin
         sb.push_back(model(op_sel_in, a_in, b_in));
         if (op_sel_in == 3'd7) err_model = 1'b1;
      end
   end

   // Monitor: occupancy-derived handshake checks and in-order result comparison.
   always @(negedge clk) begin
      if (mon_en) begin
         check("valid_op", {63'd0, valid_op}, {63'd0, sb.size() != 0});
         check("ready_op", {63'd0, ready_op}, {63'd0, sb.size() < 2});
         check("err_op", {63'd0, err_op}, {63'd0, err_model});
         if (!valid_op) begin
            check("result_when_empty", {56'd0, result_op}, 64'd0);
         end else if (ready_in) begin
            if (sb.size() == 0) check("scoreboard_underflow", 64'd1, 64'd0);
            else check("result", {56'd0, result_op}, {56'd0, sb.pop_front()});
         end
      end
   end

   task automatic reset_checks();
      check("rst_ready", {63'd0, ready_op}, 64'd0);
      check("rst_valid", {63'd0, valid_op}, 64'd0);
      check("rst_result", {56'd0, result_op}, 64'd0);
      check("rst_err", {63'd0, err_op}, 64'd0);
      check("rst_status", {61'd0, busy_op, done_op, pass_op}, 64'd0);
   endtask

   task automatic do_reset();
      mon_en    = 1'b0;
      rst       = 1'b1;
      valid_in  = 1'b0;
      sb.delete();
      err_model = 1'b0;
      #1;
      reset_checks();
      step();
      step();
      reset_checks();
      rst = 1'b0;
      step();
      check("ready_after_reset", {63'd0, ready_op}, 64'd1);
      mon_en = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [W-1:0] lit [7];
      logic [W-1:0] held;
      int           n;
      lit = '{8'h0F, 8'hC0, 8'h3F, 8'hFC, 8'h03, 8'h3C, 8'hC3};

      #3;
      reset_checks();
      step();
      do_reset();

      // Fixed operands across all legal opcodes, full throughput.
      ready_in = 1'b1;
      for (int k = 0; k < 7; k++) begin
         valid_in  = 1'b1;
         a_in      = 8'hF0;
         b_in      = 8'hCC;
         op_sel_in = 3'(k);
         step();
         check($sformatf("op%0d_latency_valid", k), {63'd0, valid_op}, 64'd1);
         check($sformatf("op%0d_result", k), {56'd0, result_op}, {56'd0, lit[k]});
      end
      valid_in = 1'b0;
      step();
      step();

      // Backpressure: two accepted, third stalls, then drains in order.
      ready_in = 1'b0;
      for (int k = 0; k < 2; k++) begin
         valid_in  = 1'b1;
         a_in      = 8'($urandom);
         b_in      = 8'($urandom);
         op_sel_in = 3'($urandom_range(0, 6));
         step();
      end
      a_in      = 8'hA5;
      b_in      = 8'h3C;
      op_sel_in = 3'd5;
      check("full_ready", {63'd0, ready_op}, 64'd0);
      held = result_op;
      step();
      step();
      check("stall_hold", {56'd0, result_op}, {56'd0, held});
      check("stall_ready", {63'd0, ready_op}, 64'd0);
      ready_in = 1'b1;
      n = 0;
      while (!ready_op && n < 20) begin
         step();
         n++;
      end
      check("third_accept_bound", {63'd0, ready_op}, 64'd1);
      step();
      valid_in = 1'b0;
      repeat (4) step();
      check("drain_no_loss", 64'(sb.size()), 64'd0);

      // Illegal opcode: zero result, sticky error.
      valid_in  = 1'b1;
      a_in      = 8'hFF;
      b_in      = 8'($urandom);
      op_sel_in = 3'd7;
      step();
      check("op7_result", {56'd0, result_op}, 64'd0);
      check("op7_err", {63'd0, err_op}, 64'd1);
      for (int k = 0; k < 10; k++) begin
         a_in      = 8'($urandom);
         b_in      = 8'($urandom);
         op_sel_in = 3'($urandom_range(0, 6));
         step();
      end
      valid_in = 1'b0;
      step();
      step();
      check("err_sticky", {63'd0, err_op}, 64'd1);
      do_reset();

      // Reset with two results pending.
      ready_in = 1'b0;
      valid_in = 1'b1;
      op_sel_in = 3'd1;
      step();
      step();
      valid_in = 1'b0;
      check("two_pending", {63'd0, valid_op}, 64'd1);
      do_reset();

      // Random traffic.
      for (int k = 0; k < 400; k++) begin
         valid_in  = ($urandom_range(0, 3) != 0);
         ready_in  = ($urandom_range(0, 2) != 0);
         a_in      = 8'($urandom);
         b_in      = 8'($urandom);
         op_sel_in = ($urandom_range(0, 15) == 0) ? 3'd7 : 3'($urandom_range(0, 6));
         step();
      end
      valid_in = 1'b0;
      ready_in = 1'b1;
      repeat (4) step();
      check("random_drain", 64'(sb.size()), 64'd0);

      // Self-test request with empty FIFO.
      mon_en   = 1'b0;
      start_in = 1'b1;
      step();
      start_in = 1'b0;
`ifdef LOGIC_UNIT_SELFTEST_EN
      n = 0;
      while (!done_op && n < 60) begin
         check("st_busy", {63'd0, busy_op}, 64'd1);
         check("st_ready", {63'd0, ready_op}, 64'd0);
         check("st_valid", {63'd0, valid_op}, 64'd0);
         step();
         n++;
      end
      check("st_done_bound", {63'd0, done_op}, 64'd1);
      check("st_pass", {63'd0, pass_op}, 64'd1);
      check("st_busy_in_done", {63'd0, busy_op}, 64'd0);
      step();
      check("st_done_pulse", {63'd0, done_op}, 64'd0);
      check("st_pass_held", {63'd0, pass_op}, 64'd1);
`else
      for (int k = 0; k < 40; k++) begin
         check("nost_status", {61'd0, busy_op, done_op, pass_op}, 64'd0);
         check("nost_ready", {63'd0, ready_op}, 64'd1);
         step();
      end
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
